// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Contents: md_op encoding, FSM state encoding, default latencies and
// small decode helpers used by the unit and by the E controller.
package mdu_pkg;

  // Operation codes driven by the E controller decode.
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int CNT_W           = 4;

  function automatic logic is_mult_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Multi-cycle ops: these occupy the unit and must stall D/E.
  function automatic logic is_long_op(input md_op_e op);
    return is_mult_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Handshake/data bundle between the E-stage controller and the MDU.
// Controller drives md_en/md_op/md_a/md_b; MDU returns busy, stall_req,
// the HI/LO registers and the mfhi/mflo read data.
interface e_mdu_if;
  import mdu_pkg::*;

  logic        md_en;
  md_op_e      md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  modport master (
    output md_en, md_op, md_a, md_b,
    input  busy, stall_req, hi, lo, md_rdata
  );

  modport slave (
    input  md_en, md_op, md_a, md_b,
    output busy, stall_req, hi, lo, md_rdata
  );

endinterface

// File: rtl/mdu_calc.sv
// Combinational mult/div datapath for the MDU.
// Ports: i_op/i_a/i_b in; o_hi/o_lo result pair and o_dz (divide by zero) out.
// Signed divide works on magnitudes, so INT_MIN / -1 wraps to INT_MIN, rem 0.
module mdu_calc
  import mdu_pkg::*;
(
  input  md_op_e      i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_dz
);

  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic        w_dz;

  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_a_neg  = w_signed & i_a[31];
  assign w_b_neg  = w_signed & i_b[31];

  // Low 64 bits of the product of sign/zero-extended operands are exact.
  assign w_ext_a = {{32{w_a_neg}}, i_a};
  assign w_ext_b = {{32{w_b_neg}}, i_b};
  assign w_prod  = w_ext_a * w_ext_b;

  assign w_mag_a = w_a_neg ? (~i_a + 32'd1) : i_a;
  assign w_mag_b = w_b_neg ? (~i_b + 32'd1) : i_b;
  assign w_dz    = (i_b == 32'd0);
  // Keep the divider's operand defined when the result is discarded anyway.
  assign w_div_b = w_dz ? 32'd1 : w_mag_b;
  assign w_uq    = w_mag_a / w_div_b;
  assign w_ur    = w_mag_a % w_div_b;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign w_q     = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
  assign w_r     = w_a_neg ? (~w_ur + 32'd1) : w_ur;

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    o_dz = 1'b0;
    if (is_mult_op(i_op)) begin
      o_hi = w_prod[63:32];
      o_lo = w_prod[31:0];
    end else if (is_div_op(i_op)) begin
      o_hi = w_r;
      o_lo = w_q;
      o_dz = w_dz;
    end
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency mult/div.
// Ports: clk, reset (sync active-low), mdu (slave side of e_mdu_if).
// Result is computed at start and held in pend_* until the counter expires.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave mdu
);

  localparam logic [CNT_W-1:0] L_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_CYCLES);

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_dz;

  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  logic [31:0]      w_pend_hi_nxt;
  logic [31:0]      w_pend_lo_nxt;
  logic             w_pend_dz_nxt;

  logic [31:0]      w_calc_hi;
  logic [31:0]      w_calc_lo;
  logic             w_calc_dz;
  logic             w_start;

  mdu_calc u_calc (
    .i_op (mdu.md_op),
    .i_a  (mdu.md_a),
    .i_b  (mdu.md_b),
    .o_hi (w_calc_hi),
    .o_lo (w_calc_lo),
    .o_dz (w_calc_dz)
  );

  assign w_start = mdu.md_en & is_long_op(mdu.md_op);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_pend_dz_nxt = r_pend_dz;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_pend_hi_nxt = w_calc_hi;
          w_pend_lo_nxt = w_calc_lo;
          w_pend_dz_nxt = w_calc_dz;
          w_cnt_nxt     = is_div_op(mdu.md_op) ? L_DIV : L_MULT;
          w_state_nxt   = ST_BUSY;
        end else if (mdu.md_en && mdu.md_op == MD_MTHI) begin
          w_hi_nxt = mdu.md_a;
        end else if (mdu.md_en && mdu.md_op == MD_MTLO) begin
          w_lo_nxt = mdu.md_a;
        end
      end
      ST_BUSY: begin
        // Any md_en request here is dropped; the hazard unit holds it in E.
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          if (!r_pend_dz) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_dz <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_dz <= w_pend_dz_nxt;
    end
  end

  assign mdu.busy      = (r_state == ST_BUSY);
  assign mdu.stall_req = mdu.busy | w_start;
  assign mdu.hi        = r_hi;
  assign mdu.lo        = r_lo;
  assign mdu.md_rdata  = (mdu.md_en && mdu.md_op == MD_MFHI) ? r_hi :
                         (mdu.md_en && mdu.md_op == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit in the Execute stage, directly upstream of the E→M pipeline register. It owns the HI/LO registers and executes mult/multu/div/divu as fixed-latency multi-cycle operations. It raises a stall request so the hazard unit freezes D/E while an operation is in flight. It serves mfhi/mflo reads and mthi/mtlo writes, and the read data is muxed into the E-stage result that the E→M register captures.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset, sampled on rising clk)
- md_en  in  1  E stage holds a valid MDU instruction this cycle
- md_op  in  4  operation code (package enum)
- md_a  in  32  rs value (forwarded)
- md_b  in  32  rt value (forwarded)
- busy  out  1  registered; high while an operation is in flight
- stall_req  out  1  combinational: busy | (md_en & op is mult/multu/div/divu)
- hi  out  32  HI register
- lo  out  32  LO register
- md_rdata  out  32  combinational: hi for MFHI, lo for MFLO, else 0

## Operation
- Ops: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- States: IDLE, BUSY. Counter cnt is 4 bits, wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, md_en & mult/div op: compute the result from md_a/md_b into pend_hi/pend_lo, load cnt = latency, go to BUSY.
- BUSY: decrement cnt each cycle. When cnt == 1, commit pend_hi/pend_lo to HI/LO on that edge and go to IDLE.
- MULT: signed 32×32 → 64. MULTU: unsigned. HI = product[63:32], LO = product[31:0].
- DIV: LO = signed quotient, truncated toward zero. HI = remainder, which takes the sign of the dividend. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (md_b == 0): full DIV_CYCLES busy, then HI/LO keep their prior values.
- MTHI/MTLO in IDLE: write md_a to HI/LO on the same edge.
- MFHI/MFLO: md_rdata is combinational from the current hi/lo.
- md_en with any op while BUSY: ignored. HI/LO and the pending results are unchanged. The hazard unit prevents this case; the block tolerates it.
- md_en = 0: md_op ignored.

## Timing
- Reset (reset = 0 at an edge): HI = 0, LO = 0, busy = 0, cnt = 0, state = IDLE, pending results cleared. md_rdata = 0. stall_req follows md_en/md_op only.
- Reset mid-operation aborts it: HI/LO go to 0 and the pending result is never committed.
- Start sampled at edge T: busy is high for cycles T+1 … T+N (N = latency). New HI/LO are visible from cycle T+N+1.
- stall_req is high in cycle T (combinational) and through T+N. The dependent mfhi in E reads the committed value at T+N+1.
- MTHI/MTLO at edge T: new value visible at T+1. MFHI in the cycle after MTHI returns the new value.
- Back-to-back starts are legal. A new mult/div is accepted in the first IDLE cycle, T+N+1.

## Structure
- Shared package `mdu_pkg`: md_op enum encoding (NONE = 0, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO), state enum, and the default latency constants.
- Decode of md_op from the instruction lives in the E controller, not here.
- One natural sub-module: `mdu_calc`, purely combinational. It computes the 64-bit mult or the div quotient/remainder pair, including the divide-by-zero flag.
- The FSM, counter and HI/LO registers stay in the top level.

## Test plan
- Reset: hold reset = 0 for 2 cycles mid-MULT → hi = lo = 0, busy = 0 next cycle; MFHI → md_rdata = 0.
- MULT, a = 0xFFFFFFFE (−2), b = 3 → busy high 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU, same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV, a = 0xFFFFFFF9 (−7), b = 2 → 10 busy cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU, a = 7, b = 2 → LO = 3, HI = 1.
- Divide by zero after MTHI 0x1234 / MTLO 0x5678 → busy 10 cycles; then HI = 0x1234, LO = 0x5678. Separately, DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- Stall/ignore: MULT 6×7, then during busy present MTLO 0xDEAD and DIV → both ignored; LO = 42 at T+6. stall_req is high cycles T..T+5 and low at T+6.
- Back-to-back: MULT commits at T+N+1 and a DIVU is accepted that same cycle; MTHI 0xAAAA followed by MFHI the next cycle → md_rdata = 0xAAAA.
